av_wr_responder: RTL
====================

AV_WR_RESPONDER -- requirements
Module: av_wr_responder

Interface
REQ-001 Parameter DEPTH, default 8, sets the FIFO entry count; it SHALL be a power of two between 2 and 64.
REQ-002 Parameter BASE_ADDR, default 16'h0000, is the decode base.
REQ-003 Parameter ADDR_MASK, default 16'hFFF0, marks the compared address bits.
REQ-004 sysclk  in  1  clock; all state SHALL change on the rising edge.
REQ-005 sysreset  in  1  reset, asynchronous, active-high.
REQ-006 av_address  in  16  Avalon-MM word address from the supervisor master.
REQ-007 av_write  in  1  write strobe.
REQ-008 av_writedata  in  16  write data.
REQ-009 av_waitrequest  out  1  stall to the master.
REQ-010 out_addr  out  4  low address bits of the head entry.
REQ-011 out_data  out  16  data of the head entry.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_ready  in  1  consumer pops the head entry.
REQ-014 level  out  7  current FIFO occupancy, 0..DEPTH.
REQ-015 drop_count  out  8  count of writes that miss the address decode.

Function
REQ-016 hit SHALL be ((av_address & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)).
REQ-017 av_waitrequest SHALL be combinational: av_write && hit && full, where full is registered (level==DEPTH).
REQ-018 Push:
- Condition: av_write && hit && !full.
- Writes {av_address[3:0], av_writedata} at the write pointer in that cycle.
REQ-019 Miss: av_write && !hit SHALL be accepted with av_waitrequest=0, discarded, and SHALL leave the FIFO unchanged.
REQ-020 out_valid SHALL be (level!=0), registered-derived.
REQ-021 out_addr/out_data SHALL present the head entry whenever out_valid=1; they are don't-care otherwise.
REQ-022 Pop: out_valid && out_ready advances the read pointer; out_ready with out_valid=0 SHALL have no effect.
REQ-023 Latency: a push into an empty FIFO SHALL give out_valid=1 on the next cycle; there is no fall-through in the same cycle.
REQ-024 Simultaneous push and pop SHALL leave level unchanged, with both pointers advancing.
REQ-025 When full, a same-cycle pop SHALL NOT permit a push; waitrequest stays high that cycle and the push lands next cycle.
REQ-026 Pointers are log2(DEPTH) bits and SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-027 av_writedata/av_address SHALL be sampled only on the accepting edge; the master holds them while waitrequest=1.
REQ-028 The block SHALL contain no combinational path from out_ready to av_waitrequest.

Reset
REQ-029 While sysreset=1:
- Pointers and level cleared.
- out_valid=0, av_waitrequest=0.
- drop_count=0.
REQ-030 Reset mid-transfer SHALL discard all stored entries and any pending stalled write.
REQ-031 FIFO storage contents need not be reset.

Configuration
REQ-032 Macro AV_WR_RESPONDER_DROP_CNT_EN controls the drop counter.
REQ-033 With the macro defined:
- drop_count is an 8-bit counter that increments once per miss-accepted cycle (REQ-019).
- It saturates at 8'hFF.
REQ-034 Without the macro, drop_count SHALL be tied to 8'h00 and no counter flops are synthesized.

Verification
REQ-035 Reset, then write addr 16'h0003, data 16'hBEEF with out_ready=0 -> waitrequest=0; next cycle out_valid=1, out_addr=4'h3, out_data=16'hBEEF, level=1.
REQ-036 Fill with DEPTH=8 writes of data 0..7, out_ready=0 -> level=8; 9th write sees waitrequest=1; pop one -> 9th accepted next cycle; drain yields 1..8 in order.
REQ-037 Continuous write and out_ready=1 for 20 cycles, data incrementing -> level stays 1 in steady state; pointers wrap; no loss or reorder.
REQ-038 Write to addr 16'h0010 (miss) 3 times -> FIFO unchanged, waitrequest=0; drop_count=3 with the macro, 0 without.
REQ-039 Assert sysreset asynchronously with level=5 and a stalled write pending -> out_valid=0, level=0, waitrequest=0 immediately.
REQ-040 Write 300 misses with the macro defined -> drop_count saturates at 8'hFF.

Source files
------------

// File: rtl/av_wr_responder.sv
`default_nettype none
// ============================================================================
// Module      : av_wr_responder
// Description : Avalon-MM write slave that decodes an address window and
//               queues {addr[3:0], data} entries into a FIFO for a consumer.
//               Optional drop counter: define AV_WR_RESPONDER_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module av_wr_responder #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hFFF0
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [15:0] av_address,
    input  logic        av_write,
    input  logic [15:0] av_writedata,
    output logic        av_waitrequest,
    output logic [3:0]  out_addr,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  level,
    output logic [7:0]  drop_count
);

    localparam int unsigned          c_ptr_w     = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]   c_ptr_one   = 1;
    localparam logic [6:0]           c_depth_lvl = 7'(DEPTH);

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]         level_q, level_d;
    logic               full_q, full_d;
    logic               valid_q, valid_d;
    logic [19:0]        mem_q [DEPTH];

    logic               w_hit;
    logic               w_push;
    logic               w_pop;
    logic [19:0]        w_head;

    assign w_hit  = (av_address & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    // Stall and push use only registered fullness, so a pop never frees a
    // slot in the same cycle and out_ready cannot reach waitrequest.
    assign w_push = av_write && w_hit && !full_q;
    assign w_pop  = valid_q && out_ready;

    assign av_waitrequest = av_write && w_hit && full_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 7'd1;
            2'b01:   level_d = level_q - 7'd1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == c_depth_lvl);
        valid_d = (level_d != 7'd0);
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 7'd0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {av_address[3:0], av_writedata};
        end
    end

    assign w_head    = mem_q[rd_ptr_q];
    assign out_addr  = w_head[19:16];
    assign out_data  = w_head[15:0];
    assign out_valid = valid_q;
    assign level     = level_q;

`ifdef AV_WR_RESPONDER_DROP_CNT_EN
    logic       w_miss;
    logic [7:0] drop_q, drop_d;

    assign w_miss = av_write && !w_hit;

    // Saturating count of writes accepted and discarded by the decode.
    always_comb begin
        drop_d = drop_q;
        if (w_miss && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            drop_q <= 8'h00;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule
`default_nettype wire
